// File: rtl/hilo_unit.sv
// HI/LO register pair with latency-modelled MULT/DIV commit, MTHI/MTLO writes and MFHI/MFLO reads.
// Optional divide-by-zero trap enabled by defining HILO_DIV0_TRAP_EN.
module hilo_unit #(
    parameter int unsigned MULT_LAT = 4,
    parameter int unsigned DIV_LAT  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_div,
    input  logic        div_zero,
    input  logic [31:0] alu_high,
    input  logic [31:0] alu_low,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    input  logic        mf_req,
    input  logic        mf_sel_hi,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        stall,
    output logic        div0_flag
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_LAT - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_LAT - 1);

    logic [0:0]  state;
    logic [3:0]  cnt;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;
    logic        commit_ok;
    logic        accept;
    logic        commit;

    assign accept = (state == IDLE) && start;
    assign commit = (state == BUSY) && (cnt == 4'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    // start has priority; a coincident MTHI/MTLO is dropped
                    if (start) begin
                        state   <= BUSY;
                        pend_hi <= alu_high;
                        pend_lo <= alu_low;
                        cnt     <= is_div ? DIV_LOAD : MULT_LOAD;
                    end else begin
                        if (mthi) hi <= wdata;
                        if (mtlo) lo <= wdata;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= IDLE;
                        if (commit_ok) begin
                            hi <= pend_hi;
                            lo <= pend_lo;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef HILO_DIV0_TRAP_EN
    logic pend_zero;
    logic flag_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_zero <= 1'b0;
            flag_q    <= 1'b0;
        end else begin
            if (accept) pend_zero <= is_div & div_zero;
            if (commit && pend_zero) flag_q <= 1'b1;
        end
    end

    assign commit_ok = ~pend_zero;
    assign div0_flag = flag_q;
`else
    logic unused_div_zero;
    assign unused_div_zero = div_zero;
    assign commit_ok       = 1'b1;
    assign div0_flag       = 1'b0;
`endif

    assign busy  = (state == BUSY);
    assign stall = busy & (start | mthi | mtlo | mf_req);
    assign rdata = mf_sel_hi ? hi : lo;

endmodule
